// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: parses a framed image (length, data, XOR checksum)
// and writes 16-bit instruction words through the instruction memory write port.
module instr_mem_loader #(
  parameter int PROG_CTR_WID = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic                    mem_we,
  output logic [PROG_CTR_WID-1:0] mem_addr,
  output logic [15:0]             mem_wdata,
  output logic                    cpu_hold,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic [PROG_CTR_WID:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_SUM = 2'b10;

  state_t                r_state, w_next;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_len;
  logic [7:0]            r_hi;
  logic [7:0]            r_xor;
  logic [PROG_CTR_WID:0] r_words;

  logic                  w_xfer;
  logic [15:0]           w_len;
  logic [PROG_CTR_WID:0] w_words_inc;
  logic                  w_len_ovf;
  logic                  w_last_word;
  logic                  w_sum_ok;

  assign w_xfer       = byte_valid & byte_ready;
  assign w_len        = {r_len_hi, byte_in};
  assign w_words_inc  = r_words + 1'b1;
  // A full-depth image (N = 2^PROG_CTR_WID) is legal; only larger counts overflow.
  assign w_len_ovf    = 32'(w_len) > (32'd1 << PROG_CTR_WID);
  assign w_last_word  = 32'(w_words_inc) == 32'(r_len);
  assign w_sum_ok     = byte_in == r_xor;
  assign words_loaded = r_words;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        cpu_hold = 1'b0;
        if (start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer) begin
          if (w_len_ovf)          w_next = S_ERR;
          else if (w_len == '0)   w_next = S_CHECK;
          else                    w_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer) w_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer) w_next = w_last_word ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer) w_next = w_sum_ok ? S_DONE : S_ERR;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        if (start) w_next = S_LEN_HI;
      end
      S_ERR: begin
        if (start) w_next = S_LEN_HI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_hi  <= '0;
      r_len     <= '0;
      r_hi      <= '0;
      r_xor     <= '0;
      r_words   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      mem_we <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            r_words  <= '0;
            r_xor    <= '0;
          end
        end
        S_LEN_HI: if (w_xfer) r_len_hi <= byte_in;
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len;
            if (w_len_ovf) begin
              err      <= 1'b1;
              err_code <= ERR_LEN;
            end
          end
        end
        S_DATA_HI: begin
          if (w_xfer) begin
            r_hi  <= byte_in;
            r_xor <= r_xor ^ byte_in;
          end
        end
        S_DATA_LO: begin
          if (w_xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= r_words[PROG_CTR_WID-1:0];
            mem_wdata <= {r_hi, byte_in};
            r_words   <= w_words_inc;
            r_xor     <= r_xor ^ byte_in;
          end
        end
        S_CHECK: begin
          if (w_xfer) begin
            if (w_sum_ok) begin
              done <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_SUM;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued as the
// DATA_LO byte is driven and compared when mem_we pulses.
module tb_instr_mem_loader;
  localparam int PCW = 10;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [7:0]     byte_in;
  logic           byte_valid;
  logic           byte_ready;
  logic           mem_we;
  logic [PCW-1:0] mem_addr;
  logic [15:0]    mem_wdata;
  logic           cpu_hold;
  logic           busy;
  logic           done;
  logic           err;
  logic [1:0]     err_code;
  logic [PCW:0]   words_loaded;

  instr_mem_loader #(.PROG_CTR_WID(PCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [PCW-1:0] addr;
    logic [15:0]    data;
  } wr_t;

  wr_t         sb[$];
  logic [7:0]  frame[$];
  logic [15:0] img[$];

  always @(negedge clk) begin
    wr_t e;
    if (mem_we) begin
      if (sb.size() == 0) begin
        check("unexpected_we", 32'(mem_we), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  // Frame from img[] with its XOR checksum, optionally corrupted by flip.
  task automatic build_frame(input logic [7:0] flip);
    logic [7:0] x;
    logic [15:0] n;
    x = 8'h00;
    n = 16'(img.size());
    frame.delete();
    frame.push_back(n[15:8]);
    frame.push_back(n[7:0]);
    foreach (img[i]) begin
      frame.push_back(img[i][15:8]);
      frame.push_back(img[i][7:0]);
      x = x ^ img[i][15:8] ^ img[i][7:0];
    end
    frame.push_back(x ^ flip);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    int t;
    if (thr) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
      end
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) check("ready_timeout", 32'(byte_ready), 32'd1);
    else             @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives frame[0..n_send-1]; pushes expected writes for the first n_words words.
  task automatic drive(input int n_send, input int n_words, input bit thr, input bit mid_start);
    pulse_start();
    check("ready_after_start", 32'(byte_ready), 32'd1);
    check("cleared_on_start", {busy, cpu_hold, done, err, err_code, 21'(words_loaded)},
          {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 21'd0});
    for (int i = 0; i < n_send; i++) begin
      if (mid_start && i == 3) pulse_start();
      if (i >= 2 && ((i - 2) % 2) == 1 && ((i - 2) / 2) < n_words)
        sb.push_back('{addr: PCW'((i - 2) / 2), data: {frame[i-1], frame[i]}});
      if (i == n_send - 1) check("hold_before_end", 32'(cpu_hold), 32'd1);
      send_byte(frame[i], thr);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic check_end(input string tag, input logic e_done, input logic e_err,
                           input logic [1:0] e_code, input int e_words, input logic e_hold);
    check({tag, "_done"},  32'(done), 32'(e_done));
    check({tag, "_err"},   32'(err), 32'(e_err));
    check({tag, "_code"},  32'(err_code), 32'(e_code));
    check({tag, "_words"}, 32'(words_loaded), 32'(e_words));
    check({tag, "_hold"},  32'(cpu_hold), 32'(e_hold));
    check({tag, "_idle"},  {30'd0, busy, byte_ready}, 32'd0);
    check({tag, "_sb"},    32'(sb.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    #12;
    check("reset_outputs",
          {byte_ready, mem_we, 10'(mem_addr), mem_wdata, cpu_hold, busy, done, err, err_code},
          32'd0);
    check("reset_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic load
    img.delete(); img.push_back(16'h1234); img.push_back(16'hABCD);
    build_frame(8'h00);
    check("basic_csum", 32'(frame[6]), 32'h40);
    drive(frame.size(), 2, 1'b0, 1'b0);
    check_end("basic", 1'b1, 1'b0, 2'b00, 2, 1'b0);

    // Bytes offered while not ready are neither consumed nor counted
    @(negedge clk); byte_valid = 1'b1; byte_in = 8'h5A;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check_end("not_ready", 1'b1, 1'b0, 2'b00, 2, 1'b0);

    // Bad checksum: writes still happen
    build_frame(8'h01);
    drive(frame.size(), 2, 1'b0, 1'b0);
    check_end("badsum", 1'b0, 1'b1, 2'b10, 2, 1'b1);

    // Length overflow 1025
    frame.delete(); frame.push_back(8'h04); frame.push_back(8'h01);
    drive(2, 0, 1'b0, 1'b0);
    check_end("ovf", 1'b0, 1'b1, 2'b01, 0, 1'b1);

    // Empty image, good and bad checksum
    img.delete();
    build_frame(8'h00);
    drive(frame.size(), 0, 1'b0, 1'b0);
    check_end("empty", 1'b1, 1'b0, 2'b00, 0, 1'b0);
    build_frame(8'h01);
    drive(frame.size(), 0, 1'b0, 1'b0);
    check_end("empty_bad", 1'b0, 1'b1, 2'b10, 0, 1'b1);

    // Throttled stream with an ignored start mid-load
    img.delete(); img.push_back(16'h1234); img.push_back(16'hABCD);
    build_frame(8'h00);
    drive(frame.size(), 2, 1'b1, 1'b1);
    check_end("throttle", 1'b1, 1'b0, 2'b00, 2, 1'b0);

    // Full-depth image, 2^PCW words
    img.delete();
    for (int i = 0; i < (1 << PCW); i++) img.push_back(16'($urandom));
    build_frame(8'h00);
    drive(frame.size(), 1 << PCW, 1'b1, 1'b0);
    check_end("full", 1'b1, 1'b0, 2'b00, 1 << PCW, 1'b0);
    check("full_last_addr", 32'(mem_addr), 32'((1 << PCW) - 1));

    // Reset after the third data byte
    img.delete(); img.push_back(16'hBEEF); img.push_back(16'h0F1E); img.push_back(16'hC0DE);
    build_frame(8'h00);
    drive(5, 3, 1'b0, 1'b0);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          {byte_ready, mem_we, 10'(mem_addr), mem_wdata, cpu_hold, busy, done, err, err_code},
          32'd0);
    check("midreset_words", 32'(words_loaded), 32'd0);
    check("midreset_sb", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(frame.size(), 3, 1'b0, 1'b0);
    check_end("after_reset", 1'b1, 1'b0, 2'b00, 3, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Byte-stream program loader that writes 16-bit instruction words into instruction memory through its write port, the write-side counterpart of the PC-addressed instruction fetch. It accepts a framed image (length header, data bytes, XOR checksum) over a valid/ready byte interface. It asserts a CPU hold while loading so the core never fetches a partially written program. It sits between the host byte link and the instruction memory write port.

## Interface
- PROG_CTR_WID, 10, instruction address width; memory depth is 2^PROG_CTR_WID words
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse to begin a load; honoured only in IDLE, DONE or ERR
- byte_in  in  8  incoming stream byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  out  PROG_CTR_WID  write address
- mem_wdata  out  16  write data, {high byte, low byte}
- cpu_hold  out  1  hold processor in reset/stall while high
- busy  out  1  load in progress
- done  out  1  sticky: last load completed with good checksum
- err  out  1  sticky: last load failed
- err_code  out  2  01 = length overflow, 10 = checksum mismatch, 00 = none
- words_loaded  out  PROG_CTR_WID+1  words written in current or last load

## Operation
- Frame format: LEN_HI, LEN_LO (word count N, big-endian, 16 bits), then 2N data bytes (per word: high byte first), then one checksum byte equal to the XOR of all 2N data bytes. Length bytes are excluded from the checksum.
- A byte transfers on any rising edge where byte_valid and byte_ready are both high. At most one byte transfers per cycle.
- States and transitions:
  - IDLE --start--> LEN_HI.
  - LEN_HI --xfer--> LEN_LO.
  - LEN_LO --xfer--> one of:
    - ERR (err_code 01) if N > 2^PROG_CTR_WID;
    - CHECK if N = 0;
    - DATA_HI otherwise.
  - DATA_HI --xfer--> DATA_LO, latching the high byte.
  - DATA_LO --xfer--> next state, issuing a write:
    - DATA_HI if words written < N;
    - CHECK once word N-1 is written.
  - CHECK --xfer--> DONE if the received byte equals the running XOR; otherwise ERR (err_code 10).
  - DONE/ERR --start--> LEN_HI. This clears done, err, err_code, words_loaded and the checksum accumulator.
- Outputs by state:
  - byte_ready = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK; 0 in IDLE, DONE, ERR.
  - busy = 1 in LEN_HI through CHECK.
  - cpu_hold = 1 in every state except IDLE and DONE. The core stays held after an error.
- Address rule: mem_addr = word index starting at 0, incremented after each write. Each write covers words 0..N-1 with no wrap. N = 2^PROG_CTR_WID is legal and writes the full memory.
- A start pulse in any busy state is ignored.
- byte_valid while byte_ready is low: the byte is not consumed and is not counted.

## Timing
- Reset (async assert, sync release) puts the block in IDLE with all outputs 0: mem_addr 0, mem_wdata 0, words_loaded 0, err_code 00.
- Reset mid-load aborts immediately. Memory contents already written are left as is; done stays 0.
- start seen at edge k: byte_ready is high from cycle k+1.
- Write latency: for the DATA_LO byte accepted at edge k, mem_we, mem_addr and mem_wdata are registered and valid for exactly the cycle following edge k. words_loaded increments at edge k.
- DONE/ERR entry: done/err, err_code and the cpu_hold drop (DONE case) all change at the edge that accepts the checksum byte or LEN_LO.
- Back-to-back bytes at full rate: one word is written every 2 cycles. The minimum load time is 2N+3 cycles after start.

## Test plan
- Basic load, PROG_CTR_WID=10: start, then bytes 00 02 12 34 AB CD with checksum 12^34^AB^CD = 40. Required:
  - mem_we pulses write addr 0 = 0x1234 and addr 1 = 0xABCD;
  - done=1, words_loaded=2;
  - cpu_hold falls the cycle DONE is entered.
- Bad checksum: same frame with checksum 41. Required:
  - both writes still occur;
  - err=1, err_code=10, cpu_hold stays 1, byte_ready=0.
- Length overflow: LEN 04 01 (1025 > 1024). Required: err_code=01 after LEN_LO, no mem_we, words_loaded=0.
- Empty image: LEN 00 00, checksum 00. Required: done=1 with no write; checksum 01 instead gives err_code=10.
- Throttled stream plus ignored start: toggle byte_valid randomly and pulse start mid-load. Required: identical memory image and counts to the full-rate run; no restart.
- Reset mid-load: assert rst_n=0 after the 3rd data byte. Required:
  - all outputs 0 immediately;
  - the next start runs a full correct load from address 0.
